// File: rtl/mvm_pkg.sv
// Shared types for the matrix-vector multiply sequencer: FSM state encoding
// and the matrix-ROM address width helper.
package mvm_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } mvm_state_t;

  function automatic int addr_w_bits(input int m, input int n);
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

endpackage

// File: rtl/mvm_control_if.sv
// Control bundle between the sequencer, the vector/matrix memories, the MAC
// datapath and the upstream/downstream handshakes.
interface mvm_control_if #(
  parameter int M = 4,
  parameter int N = 4
);
  import mvm_pkg::*;

  localparam int XW = $clog2(N);
  localparam int WW = addr_w_bits(M, N);

  logic          input_valid;
  logic          input_ready;
  logic          wr_en_x;
  logic [XW-1:0] addr_x;
  logic [WW-1:0] addr_w;
  logic          clear_acc;
  logic          en_acc;
  logic          output_valid;
  logic          output_ready;

  modport master (
    input  input_valid, output_ready,
    output input_ready, wr_en_x, addr_x, addr_w, clear_acc, en_acc, output_valid
  );

  modport slave (
    output input_valid, output_ready,
    input  input_ready, wr_en_x, addr_x, addr_w, clear_acc, en_acc, output_valid
  );

endinterface

// File: rtl/mvm_control_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the increment that
// rolls the count from MOD-1 back to 0.
module mod_counter #(
  parameter  int MOD = 4,
  localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/mvm_control.sv
// Sequencer for the saturating matrix-vector engine: loads an N-element vector,
// then walks M rows issuing ROM/RAM addresses and accumulator strobes.
module mvm_control
  import mvm_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int DP_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mvm_control_if.master bus
);

  localparam int XW = $clog2(N);
  localparam int WW = addr_w_bits(M, N);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int DW = $clog2(DP_LAT + 1);

  mvm_state_t    state, state_nx;
  logic [XW-1:0] col;
  logic          col_wrap;
  logic [RW-1:0] row;
  logic          row_wrap;
  logic [WW-1:0] aw;
  logic [DW-1:0] drain_cnt;
  logic          en_q;
  logic          accept, issue, handoff;

  assign accept  = (state == LOAD) && bus.input_valid;
  assign issue   = (state == MAC);
  assign handoff = (state == OUT) && bus.output_ready;

  // One counter serves as element index while loading and column while computing.
  mod_counter #(.MOD(N)) u_col (
    .clk   (clk),
    .reset (reset),
    .clr   (state == CLEAR),
    .inc   (accept || issue),
    .count (col),
    .wrap  (col_wrap)
  );

  mod_counter #(.MOD(M)) u_row (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .inc   (handoff),
    .count (row),
    .wrap  (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (col_wrap) state_nx = CLEAR;
      CLEAR:   state_nx = MAC;
      MAC:     if (col_wrap) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nx = OUT;
      OUT:     if (handoff) state_nx = row_wrap ? LOAD : CLEAR;
      default: state_nx = LOAD;
    endcase
  end

  // en_acc trails the address issue by one cycle to match the memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw        <= '0;
      drain_cnt <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= issue;
      if (state == LOAD)
        aw <= '0;
      else if (issue)
        aw <= (col_wrap && row == RW'(M - 1)) ? '0 : aw + WW'(1);
      if (issue && col_wrap)
        drain_cnt <= DW'(DP_LAT - 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);
    end
  end

  always_comb begin
    bus.input_ready  = 1'b0;
    bus.wr_en_x      = 1'b0;
    bus.clear_acc    = 1'b0;
    bus.output_valid = 1'b0;
    bus.addr_x       = col;
    bus.addr_w       = aw;
    bus.en_acc       = en_q;
    case (state)
      LOAD: begin
        bus.input_ready = !reset;
        bus.wr_en_x     = bus.input_valid && !reset;
      end
      CLEAR:   bus.clear_acc    = 1'b1;
      OUT:     bus.output_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mvm_control.sv
// Directed bench for mvm_control: expected writes, strobes, addresses and
// handoff cycles are queued up front and popped as the DUT produces them.
module tb_mvm_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic iv = 1'b0;
  logic ordy = 1'b0;

  always #5 clk = ~clk;

  mvm_control_if #(.M(4), .N(4)) if0 ();
  mvm_control_if #(.M(1), .N(2)) if1 ();

  assign if0.input_valid  = iv;
  assign if0.output_ready = ordy;
  assign if1.input_valid  = iv;
  assign if1.output_ready = ordy;

  mvm_control #(.M(4), .N(4), .DP_LAT(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  mvm_control #(.M(1), .N(2), .DP_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int errors = 0;
  int checks = 0;
  int sel = 0;
  int mm = 4, nn = 4, dp = 2;

  logic [31:0] s_wr, s_ax, s_aw, s_clr, s_en, s_ov, s_ir;

  int wr_q[$], clr_q[$], en_q[$], aw_q[$], ax_q[$], hs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      s_wr = 32'(if0.wr_en_x);   s_ax = 32'(if0.addr_x);  s_aw = 32'(if0.addr_w);
      s_clr = 32'(if0.clear_acc); s_en = 32'(if0.en_acc); s_ov = 32'(if0.output_valid);
      s_ir = 32'(if0.input_ready);
    end else begin
      s_wr = 32'(if1.wr_en_x);   s_ax = 32'(if1.addr_x);  s_aw = 32'(if1.addr_w);
      s_clr = 32'(if1.clear_acc); s_en = 32'(if1.en_acc); s_ov = 32'(if1.output_valid);
      s_ir = 32'(if1.input_ready);
    end
  endtask

  // Pops the scoreboard for every event seen this cycle; an event with nothing queued is an error.
  task automatic monitor(input int c, input logic [31:0] p_aw, input logic [31:0] p_ax);
    if (s_wr == 1) begin
      if (wr_q.size() > 0) chk("wr_addr", s_ax, wr_q.pop_front());
      else chk("wr_extra", s_wr, 0);
    end
    if (s_clr == 1) begin
      if (clr_q.size() > 0) chk("clear_cycle", c, clr_q.pop_front());
      else chk("clear_extra", s_clr, 0);
    end
    if (s_en == 1) begin
      if (en_q.size() > 0) begin
        chk("en_cycle", c, en_q.pop_front());
        chk("issue_addr_w", p_aw, aw_q.pop_front());
        chk("issue_addr_x", p_ax, ax_q.pop_front());
      end else chk("en_extra", s_en, 0);
    end
    if (s_ov == 1 && ordy) begin
      if (hs_q.size() > 0) chk("handoff_cycle", c, hs_q.pop_front());
      else chk("handoff_extra", s_ov, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; iv = 1'b1; ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample();
    chk("rst_ready", s_ir, 0);
    chk("rst_wr", s_wr, 0);
    chk("rst_en", s_en, 0);
    chk("rst_clear", s_clr, 0);
    chk("rst_valid", s_ov, 0);
    chk("rst_addr", s_ax | s_aw, 0);
    reset = 1'b0; iv = 1'b0; ordy = 1'b0;
  endtask

  // pat: input_valid per cycle; srow/slen: row whose handoff is stalled and for how long.
  task automatic run_vec(input bit [15:0] pat, input int npat, input int srow, input int slen);
    int k, la, b, ws, hs, irc;
    logic [31:0] p_aw, p_ax;
    k = 0; la = 0;
    for (int t = 0; t < npat; t++)
      if (pat[t]) begin wr_q.push_back(k); k++; la = t; end
    b = la + 1; ws = -1;
    for (int r = 0; r < mm; r++) begin
      clr_q.push_back(b);
      for (int c = 0; c < nn; c++) begin
        en_q.push_back(b + 2 + c);
        aw_q.push_back(r * nn + c);
        ax_q.push_back(c);
      end
      hs = b + nn + dp + 1;
      if (r == srow) begin ws = hs; hs += slen; end
      hs_q.push_back(hs);
      b = hs + 1;
    end
    irc = b;
    p_aw = 0; p_ax = 0;
    for (int c = 0; c <= irc; c++) begin
      @(posedge clk); #1;
      iv   = (c < npat) ? pat[c] : (c < irc);
      ordy = !(ws >= 0 && c >= ws && c < ws + slen);
      @(negedge clk);
      sample();
      if (c == 0) chk("ready_first", s_ir, 1);
      if (c == la + 1) chk("ready_low", s_ir, 0);
      if (c == irc) begin
        chk("ready_back", s_ir, 1);
        chk("addr_w_load", s_aw, 0);
      end
      if (!ordy) begin
        chk("stall_valid", s_ov, 1);
        chk("stall_addr_w", s_aw, (srow + 1) * nn);
      end
      monitor(c, p_aw, p_ax);
      p_aw = s_aw; p_ax = s_ax;
    end
    iv = 1'b0;
    chk("wr_left", wr_q.size(), 0);
    chk("clear_left", clr_q.size(), 0);
    chk("en_left", en_q.size(), 0);
    chk("handoff_left", hs_q.size(), 0);
  endtask

  initial begin
    sel = 0; mm = 4; nn = 4; dp = 2;
    do_reset();
    run_vec(16'h000F, 4, -1, 0);
    run_vec(16'h000F, 4, 1, 5);
    run_vec(16'h0059, 7, -1, 0);

    // Reset mid-MAC, then a fresh vector.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      iv = (c < 4); ordy = 1'b1; reset = (c == 7);
      @(negedge clk);
      sample();
      if (c == 7) chk("pre_reset_en", s_en, 1);
      if (c == 8) begin
        chk("mid_reset_en", s_en, 0);
        chk("mid_reset_ready", s_ir, 1);
        chk("mid_reset_addr_x", s_ax, 0);
        chk("mid_reset_valid", s_ov, 0);
      end
    end
    iv = 1'b0;
    run_vec(16'h000F, 4, -1, 0);

    sel = 1; mm = 1; nn = 2; dp = 1;
    do_reset();
    run_vec(16'h0003, 2, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
